// File: rtl/fcache_stack.sv
// Function-call cache: a LIFO of DEPTH frames (NREGS registers + return address).
// A backup pushes a frame and a restore pops one; when both arrive together the top frame is swapped.
module fcache_stack #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 15,
    parameter int DEPTH  = 8,
    localparam int FRAME_W = (NREGS + 1) * DATA_W,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               backup,
    input  logic               restore,
    input  logic               clr_err,
    input  logic [FRAME_W-1:0] frame_in,
    output logic [FRAME_W-1:0] frame_out,
    output logic               restore_vld,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               underflow,
    output logic [CNT_W-1:0]   high_water
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FRAME_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             pop;
    logic             ovf_set;
    logic             unf_set;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_idx = IDX_W'(count);
    assign top_idx  = IDX_W'(count - CNT_W'(1));

    always_comb begin
        cnt_nxt = count;
        wr_en   = 1'b0;
        wr_idx  = push_idx;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case ({backup, restore})
            2'b10: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    cnt_nxt = count + CNT_W'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cnt_nxt = count - CNT_W'(1);
                end else begin
                    unf_set = 1'b1;
                end
            end
            2'b11: begin
                if (!empty) begin
                    // Swap: the old top is read out while the new frame replaces it.
                    pop    = 1'b1;
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end else begin
                    wr_en   = 1'b1;
                    cnt_nxt = CNT_W'(1);
                    unf_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Storage is not reset; slots above count are never read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= frame_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            frame_out   <= '0;
            restore_vld <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            high_water  <= '0;
        end else begin
            count       <= cnt_nxt;
            restore_vld <= pop;
            if (pop) frame_out <= mem[top_idx];
            // A new error in the same cycle as clr_err keeps the flag set.
            overflow    <= ovf_set | (overflow  & ~clr_err);
            underflow   <= unf_set | (underflow & ~clr_err);
            if (cnt_nxt > high_water) high_water <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fcache_stack.sv
// Directed testbench for fcache_stack: reset, nesting, full/overflow, underflow, swap and
// simultaneous backup/restore on an empty stack.
module tb_fcache_stack;

    localparam int DATA_W  = 16;
    localparam int NREGS   = 15;
    localparam int DEPTH   = 8;
    localparam int FRAME_W = (NREGS + 1) * DATA_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic               clk;
    logic               rst_n;
    logic               backup;
    logic               restore;
    logic               clr_err;
    logic [FRAME_W-1:0] frame_in;
    logic [FRAME_W-1:0] frame_out;
    logic               restore_vld;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               overflow;
    logic               underflow;
    logic [CNT_W-1:0]   high_water;

    int tests;
    int failed;

    fcache_stack #(.DATA_W(DATA_W), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .backup(backup), .restore(restore), .clr_err(clr_err),
        .frame_in(frame_in), .frame_out(frame_out), .restore_vld(restore_vld), .count(count),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
        .high_water(high_water)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FRAME_W-1:0] mk(input logic [15:0] ra, input logic [15:0] r);
        return {ra, {NREGS{r}}};
    endfunction

    // One clock with the given controls; outputs are stable 1 time unit after the edge.
    task automatic step(input logic b, input logic r, input logic c, input logic [FRAME_W-1:0] f);
        backup = b; restore = r; clr_err = c; frame_in = f;
        @(posedge clk); #1;
        backup = 1'b0; restore = 1'b0; clr_err = 1'b0; frame_in = '0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin failed++; $display("FAIL reset_init count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
        step(1, 0, 0, mk(16'hBEEF, 16'h0F0F));
        step(1, 0, 0, mk(16'hCAFE, 16'hF0F0));
        step(0, 1, 0, '0);
        tests++; if (frame_out !== mk(16'hCAFE, 16'hF0F0) || restore_vld !== 1'b1 || count !== 4'd1) begin failed++; $display("FAIL reset_pre frame_out=%h vld=%b count=%0d", frame_out, restore_vld, count); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || frame_out !== '0 || restore_vld !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || high_water !== 4'd0) begin
            failed++; $display("FAIL reset_async count=%0d empty=%b full=%b frame_out=%h vld=%b ovf=%b unf=%b hw=%0d want all zero, empty=1", count, empty, full, frame_out, restore_vld, overflow, underflow, high_water);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (count !== 4'd0 || empty !== 1'b1) begin failed++; $display("FAIL reset_release count=%0d empty=%b want 0/1", count, empty); end
    endtask

    task automatic test_nesting;
        step(1, 0, 0, mk(16'h0010, 16'h1111));
        step(1, 0, 0, mk(16'h0020, 16'h2222));
        step(1, 0, 0, mk(16'h0030, 16'h3333));
        tests++; if (count !== 4'd3 || empty !== 1'b0 || restore_vld !== 1'b0) begin failed++; $display("FAIL nest_push count=%0d empty=%b vld=%b want 3/0/0", count, empty, restore_vld); end
        step(0, 1, 0, '0);
        tests++; if (frame_out !== mk(16'h0030, 16'h3333) || restore_vld !== 1'b1 || count !== 4'd2) begin failed++; $display("FAIL nest_pop3 frame_out=%h vld=%b count=%0d want F3/1/2", frame_out, restore_vld, count); end
        step(0, 1, 0, '0);
        tests++; if (frame_out !== mk(16'h0020, 16'h2222) || restore_vld !== 1'b1 || count !== 4'd1) begin failed++; $display("FAIL nest_pop2 frame_out=%h vld=%b count=%0d want F2/1/1", frame_out, restore_vld, count); end
        step(0, 1, 0, '0);
        tests++; if (frame_out !== mk(16'h0010, 16'h1111) || restore_vld !== 1'b1 || count !== 4'd0 || empty !== 1'b1) begin failed++; $display("FAIL nest_pop1 frame_out=%h vld=%b count=%0d empty=%b want F1/1/0/1", frame_out, restore_vld, count, empty); end
        step(0, 0, 0, '0);
        tests++; if (restore_vld !== 1'b0 || high_water !== 4'd3 || frame_out !== mk(16'h0010, 16'h1111)) begin failed++; $display("FAIL nest_idle vld=%b hw=%0d frame_out=%h want 0/3/F1", restore_vld, high_water, frame_out); end
    endtask

    task automatic test_full;
        for (int i = 1; i <= 8; i++) step(1, 0, 0, mk(16'h0100 + 16'(i), 16'h1000 * 16'(i)));
        tests++; if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0 || high_water !== 4'd8) begin failed++; $display("FAIL full_8 count=%0d full=%b ovf=%b hw=%0d want 8/1/0/8", count, full, overflow, high_water); end
        step(1, 0, 0, mk(16'h0109, 16'h9000));
        tests++; if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b1) begin failed++; $display("FAIL full_9th count=%0d full=%b ovf=%b want 8/1/1", count, full, overflow); end
        for (int i = 8; i >= 1; i--) begin
            step(0, 1, 0, '0);
            tests++; if (frame_out !== mk(16'h0100 + 16'(i), 16'h1000 * 16'(i)) || restore_vld !== 1'b1 || count !== 4'(i - 1)) begin
                failed++; $display("FAIL full_pop%0d frame_out=%h vld=%b count=%0d want RA %h count %0d", i, frame_out, restore_vld, count, 16'h0100 + 16'(i), i - 1);
            end
        end
        tests++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b1 || high_water !== 4'd8) begin failed++; $display("FAIL full_drained empty=%b full=%b ovf=%b hw=%0d want 1/0/1/8", empty, full, overflow, high_water); end
        step(0, 0, 1, '0);
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL full_clr ovf=%b want 0", overflow); end
    endtask

    task automatic test_underflow;
        step(0, 1, 0, '0);
        tests++; if (underflow !== 1'b1 || restore_vld !== 1'b0 || count !== 4'd0 || frame_out !== mk(16'h0101, 16'h1000)) begin
            failed++; $display("FAIL unf_set unf=%b vld=%b count=%0d frame_out=%h want 1/0/0/frame1", underflow, restore_vld, count, frame_out);
        end
        step(0, 1, 1, '0);
        tests++; if (underflow !== 1'b1) begin failed++; $display("FAIL unf_clr_vs_err unf=%b want 1", underflow); end
        step(0, 0, 1, '0);
        tests++; if (underflow !== 1'b0 || overflow !== 1'b0) begin failed++; $display("FAIL unf_clr unf=%b ovf=%b want 0/0", underflow, overflow); end
    endtask

    task automatic test_swap;
        step(1, 0, 0, mk(16'h0042, 16'h4242));
        step(1, 0, 0, mk(16'hAAAA, 16'hAAAA));
        step(1, 1, 0, mk(16'h5555, 16'h5555));
        tests++; if (frame_out !== mk(16'hAAAA, 16'hAAAA) || restore_vld !== 1'b1 || count !== 4'd2 || underflow !== 1'b0) begin
            failed++; $display("FAIL swap frame_out=%h vld=%b count=%0d unf=%b want AAAA/1/2/0", frame_out, restore_vld, count, underflow);
        end
        step(0, 1, 0, '0);
        tests++; if (frame_out !== mk(16'h5555, 16'h5555) || count !== 4'd1) begin failed++; $display("FAIL swap_pop frame_out=%h count=%0d want 5555/1", frame_out, count); end
        step(0, 1, 0, '0);
        tests++; if (frame_out !== mk(16'h0042, 16'h4242) || count !== 4'd0) begin failed++; $display("FAIL swap_pop2 frame_out=%h count=%0d want 0042/0", frame_out, count); end
    endtask

    task automatic test_br_empty;
        step(1, 1, 0, mk(16'h1234, 16'h1234));
        tests++; if (count !== 4'd1 || underflow !== 1'b1 || restore_vld !== 1'b0 || frame_out !== mk(16'h0042, 16'h4242)) begin
            failed++; $display("FAIL br_empty count=%0d unf=%b vld=%b frame_out=%h want 1/1/0/0042", count, underflow, restore_vld, frame_out);
        end
        step(0, 1, 0, '0);
        tests++; if (frame_out !== mk(16'h1234, 16'h1234) || restore_vld !== 1'b1 || count !== 4'd0) begin failed++; $display("FAIL br_empty_pop frame_out=%h vld=%b count=%0d want 1234/1/0", frame_out, restore_vld, count); end
    endtask

    initial begin
        tests = 0; failed = 0;
        backup = 1'b0; restore = 1'b0; clr_err = 1'b0; frame_in = '0; rst_n = 1'b0;
        test_reset();
        test_nesting();
        test_full();
        test_underflow();
        test_swap();
        test_br_empty();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
